// File: rtl/ram_dual_port_pkg.sv
// Shared constants and parameter legality check for ram_dual_port.
package ram_dual_port_pkg;

    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 2;

    // Returns 1 when the port geometry and latency form a supported configuration.
    function automatic bit params_ok(
        input int unsigned wa,
        input int unsigned wb,
        input int unsigned ada,
        input int unsigned adb,
        input int unsigned bea,
        input int unsigned beb,
        input int unsigned nwa,
        input int unsigned nwb,
        input int unsigned lat
    );
        bit ok;
        ok = (wa == wb) && (ada == adb) && (nwa == nwb);
        ok = ok && (bea != 0) && (beb != 0) && ((wa % bea) == 0) && ((wb % beb) == 0);
        ok = ok && (nwa != 0) && (ada > 0) && (ada < 32) && (nwa <= (32'd1 << ada));
        ok = ok && (lat >= LAT_MIN) && (lat <= LAT_MAX);
        return ok;
    endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// Read-data register chain of configurable depth; holds when en_i is low and
// clears asynchronously on reset so no stale data leaves after release.
module ram_read_pipe
    import ram_dual_port_pkg::*;
#(
    parameter int unsigned Width   = 32,
    parameter int unsigned Latency = LAT_MIN
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] stage_q [Latency];
    logic [Width-1:0] stage_d [Latency];

    // Shift one stage per enabled clock, otherwise hold every stage.
    always_comb begin
        stage_d = stage_q;
        if (en_i) begin
            stage_d[0] = d_i;
            for (int i = 1; i < Latency; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Pipeline state with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '{default: '0};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q[Latency-1];

endmodule

// File: rtl/ram_dual_port.sv
// True dual-port synchronous RAM, shared clock, read-first on both ports.
// Port B wins on overlapping enabled lanes when both ports write one word.
module ram_dual_port
    import ram_dual_port_pkg::*;
#(
    parameter int unsigned width_a    = 32,
    parameter int unsigned width_b    = 32,
    parameter int unsigned widthad_a  = 3,
    parameter int unsigned widthad_b  = 3,
    parameter int unsigned width_be_a = 1,
    parameter int unsigned width_be_b = 1,
    parameter int unsigned numwords_a = 8,
    parameter int unsigned numwords_b = 8,
    parameter int unsigned latency    = 1,
    parameter              init_file  = "UNUSED"
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clken,
    input  logic [widthad_a-1:0]  address_a,
    input  logic [widthad_b-1:0]  address_b,
    input  logic                  wren_a,
    input  logic                  wren_b,
    input  logic [width_a-1:0]    data_a,
    input  logic [width_b-1:0]    data_b,
    input  logic [width_be_a-1:0] byteena_a,
    input  logic [width_be_b-1:0] byteena_b,
    output logic [width_a-1:0]    q_a,
    output logic [width_b-1:0]    q_b
);

    localparam int unsigned LaneA = width_a / width_be_a;
    localparam int unsigned LaneB = width_b / width_be_b;
    localparam int unsigned Depth = 32'd1 << widthad_a;

    if (!params_ok(width_a, width_b, widthad_a, widthad_b, width_be_a, width_be_b,
                   numwords_a, numwords_b, latency)) begin : g_param_err
        $error("ram_dual_port: unsupported parameter combination");
    end

    // Sized to the full address space so any address indexes legally; words at or
    // above numwords are never written and always read as zero.
    logic [width_a-1:0] mem [Depth];

    initial mem = '{default: '0};

    logic [width_a-1:0] mask_a, mask_b;
    logic [width_a-1:0] wdata_a, wdata_b, base_b;
    logic [width_a-1:0] rdata_a, rdata_b;
    logic               in_a, in_b, we_a, we_b, same_addr;

    // Lane masks, write merges and range-checked read data for both ports.
    always_comb begin
        mask_a = '0;
        mask_b = '0;
        for (int k = 0; k < width_be_a; k++) begin
            mask_a[k*LaneA +: LaneA] = {LaneA{byteena_a[k]}};
        end
        for (int k = 0; k < width_be_b; k++) begin
            mask_b[k*LaneB +: LaneB] = {LaneB{byteena_b[k]}};
        end
        in_a      = (32'(address_a) < numwords_a);
        in_b      = (32'(address_b) < numwords_b);
        we_a      = clken & resetn & wren_a & in_a;
        we_b      = clken & resetn & wren_b & in_b;
        same_addr = (address_a == address_b);
        wdata_a   = (mem[address_a] & ~mask_a) | (data_a & mask_a);
        // On a shared address, B merges on top of A's result so A's
        // non-overlapping lanes survive.
        base_b    = (we_a && same_addr) ? wdata_a : mem[address_b];
        wdata_b   = (base_b & ~mask_b) | (data_b & mask_b);
        rdata_a   = in_a ? mem[address_a] : '0;
        rdata_b   = in_b ? mem[address_b] : '0;
    end

    // Array writes; a shared-address collision is committed once from port B.
    always_ff @(posedge clk) begin
        if (we_a && !(we_b && same_addr)) begin
            mem[address_a] <= wdata_a;
        end
        if (we_b) begin
            mem[address_b] <= wdata_b;
        end
    end

    ram_read_pipe #(
        .Width   (width_a),
        .Latency (latency)
    ) u_pipe_a (
        .clk_i  (clk),
        .rst_ni (resetn),
        .en_i   (clken),
        .d_i    (rdata_a),
        .q_o    (q_a)
    );

    ram_read_pipe #(
        .Width   (width_b),
        .Latency (latency)
    ) u_pipe_b (
        .clk_i  (clk),
        .rst_ni (resetn),
        .en_i   (clken),
        .d_i    (rdata_b),
        .q_o    (q_b)
    );

endmodule

// File: tb/tb_ram_dual_port.sv
// Bench for ram_dual_port: a default instance (whole-word enables, latency 1)
// driven from a vector table, and a 4-lane, latency-2, 6-word instance driven
// by hand sequences for lanes, range, clock-enable gaps and reset.
module tb_ram_dual_port;

    logic        clk = 1'b0;
    logic        resetn;
    logic        clken;

    logic [2:0]  a_addr, b_addr;
    logic        a_wren, b_wren;
    logic [31:0] a_data, b_data;
    logic [0:0]  a_be, b_be;
    logic [31:0] q_a0, q_b0;

    logic [2:0]  xa_addr, xb_addr;
    logic        xa_wren, xb_wren;
    logic [31:0] xa_data, xb_data;
    logic [3:0]  xa_be, xb_be;
    logic [31:0] q_a1, q_b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_dual_port u_dut0 (
        .clk       (clk),
        .resetn    (resetn),
        .clken     (clken),
        .address_a (a_addr),
        .address_b (b_addr),
        .wren_a    (a_wren),
        .wren_b    (b_wren),
        .data_a    (a_data),
        .data_b    (b_data),
        .byteena_a (a_be),
        .byteena_b (b_be),
        .q_a       (q_a0),
        .q_b       (q_b0)
    );

    ram_dual_port #(
        .width_be_a (4),
        .width_be_b (4),
        .numwords_a (6),
        .numwords_b (6),
        .latency    (2)
    ) u_dut1 (
        .clk       (clk),
        .resetn    (resetn),
        .clken     (clken),
        .address_a (xa_addr),
        .address_b (xb_addr),
        .wren_a    (xa_wren),
        .wren_b    (xb_wren),
        .data_a    (xa_data),
        .data_b    (xb_data),
        .byteena_a (xa_be),
        .byteena_b (xb_be),
        .q_a       (q_a1),
        .q_b       (q_b1)
    );

    typedef struct {
        logic        en;
        logic        wa;
        logic [2:0]  aa;
        logic [31:0] da;
        logic [0:0]  ba;
        logic        wb;
        logic [2:0]  ab;
        logic [31:0] db;
        logic [0:0]  bb;
        logic [31:0] eqa;
        logic [31:0] eqb;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic x_drive(input logic wa, input logic [2:0] aa, input logic [31:0] da,
                           input logic [3:0] ba, input logic wb, input logic [2:0] ab,
                           input logic [31:0] db, input logic [3:0] bb);
        xa_wren = wa; xa_addr = aa; xa_data = da; xa_be = ba;
        xb_wren = wb; xb_addr = ab; xb_data = db; xb_be = bb;
    endtask

    initial begin
        //          en wa aa    da            ba wb ab    db            bb eqa           eqb
        vecs[0]  = '{1, 0, 3'd7, 32'h0,        0, 0, 3'd6, 32'h0,        0, 32'h0,        32'h0};
        vecs[1]  = '{1, 1, 3'd3, 32'hDEADBEEF, 1, 0, 3'd3, 32'h0,        0, 32'h0,        32'h0};
        vecs[2]  = '{1, 0, 3'd3, 32'h0,        0, 0, 3'd0, 32'h0,        0, 32'hDEADBEEF, 32'h0};
        vecs[3]  = '{1, 0, 3'd3, 32'h0,        0, 1, 3'd5, 32'h22,       1, 32'hDEADBEEF, 32'h0};
        vecs[4]  = '{1, 1, 3'd5, 32'h11,       1, 0, 3'd5, 32'h0,        0, 32'h22,       32'h22};
        vecs[5]  = '{1, 0, 3'd5, 32'h0,        0, 0, 3'd5, 32'h0,        0, 32'h11,       32'h11};
        vecs[6]  = '{1, 1, 3'd2, 32'hAAAAAAAA, 1, 1, 3'd2, 32'h55555555, 1, 32'h0,        32'h0};
        vecs[7]  = '{1, 0, 3'd2, 32'h0,        0, 0, 3'd3, 32'h0,        0, 32'h55555555, 32'hDEADBEEF};
        vecs[8]  = '{1, 1, 3'd4, 32'h1234,     0, 1, 3'd6, 32'hCAFE,     1, 32'h0,        32'h0};
        vecs[9]  = '{1, 0, 3'd4, 32'h0,        0, 0, 3'd6, 32'h0,        0, 32'h0,        32'hCAFE};
        vecs[10] = '{1, 1, 3'd1, 32'h77,       1, 1, 3'd1, 32'h99,       0, 32'h0,        32'h0};
        vecs[11] = '{1, 0, 3'd1, 32'h0,        0, 0, 3'd1, 32'h0,        0, 32'h77,       32'h77};
        vecs[12] = '{0, 1, 3'd3, 32'h0,        1, 0, 3'd5, 32'h0,        0, 32'h77,       32'h77};
        vecs[13] = '{1, 0, 3'd3, 32'h0,        0, 0, 3'd5, 32'h0,        0, 32'hDEADBEEF, 32'h11};

        resetn = 1'b0;
        clken  = 1'b1;
        a_wren = 0; a_addr = 0; a_data = 0; a_be = 0;
        b_wren = 0; b_addr = 0; b_data = 0; b_be = 0;
        x_drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("reset_qa0", q_a0, 32'h0);
        check("reset_qb0", q_b0, 32'h0);
        check("reset_qa1", q_a1, 32'h0);
        check("reset_qb1", q_b1, 32'h0);
        #10;
        resetn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            clken  = vecs[i].en;
            a_wren = vecs[i].wa; a_addr = vecs[i].aa; a_data = vecs[i].da; a_be = vecs[i].ba;
            b_wren = vecs[i].wb; b_addr = vecs[i].ab; b_data = vecs[i].db; b_be = vecs[i].bb;
            step();
            check($sformatf("vec%0d_qa", i), q_a0, vecs[i].eqa);
            check($sformatf("vec%0d_qb", i), q_b0, vecs[i].eqb);
        end
        a_wren = 0; b_wren = 0;
        clken  = 1'b1;

        // Lane enables, lane merging on a shared address, out-of-range address.
        x_drive(0, 0, 0, 0, 1, 0, 32'h0, 4'hF);                                   step();
        x_drive(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 4'b0101);                         step();
        x_drive(1, 1, 32'h11223344, 4'hF, 1, 1, 32'hAABBCCDD, 4'b0110);           step();
        x_drive(1, 4, 32'h11223344, 4'b0011, 1, 4, 32'hAABBCCDD, 4'b1100);        step();
        x_drive(1, 6, 32'h12345678, 4'hF, 0, 0, 0, 0);                            step();
        x_drive(0, 6, 0, 0, 0, 0, 0, 0);
        step(); step();
        check("oor_read_qa1", q_a1, 32'h0);
        check("byteena_qb1", q_b1, 32'h00FF00FF);
        x_drive(0, 1, 0, 0, 0, 4, 0, 0);
        step(); step();
        check("overlap_qa1", q_a1, 32'h11BBCC44);
        check("disjoint_qb1", q_b1, 32'hAABB3344);

        // Latency 2 with a clock-enable gap between address and output.
        x_drive(0, 0, 0, 0, 0, 4, 0, 0);
        step();
        check("lat2_edge1_qa1", q_a1, 32'h11BBCC44);
        clken = 1'b0;
        step();
        check("lat2_gap_qa1", q_a1, 32'h11BBCC44);
        check("lat2_gap_qb1", q_b1, 32'hAABB3344);
        clken = 1'b1;
        step();
        check("lat2_edge2_qa1", q_a1, 32'h00FF00FF);

        // Reset in the middle of reads; array contents must survive.
        a_addr = 5; b_addr = 2;
        x_drive(0, 1, 0, 0, 0, 0, 0, 0);
        step();
        check("pre_reset_qa0", q_a0, 32'h11);
        check("pre_reset_qb0", q_b0, 32'h55555555);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_qa0", q_a0, 32'h0);
        check("async_reset_qb0", q_b0, 32'h0);
        check("async_reset_qa1", q_a1, 32'h0);
        check("async_reset_qb1", q_b1, 32'h0);
        a_wren = 1; a_data = 32'hBAD; a_be = 1;
        x_drive(1, 1, 32'h0, 4'hF, 0, 0, 0, 0);
        step();
        check("in_reset_qa0", q_a0, 32'h0);
        check("in_reset_qa1", q_a1, 32'h0);
        resetn = 1'b1;
        a_wren = 0;
        x_drive(0, 1, 0, 0, 0, 0, 0, 0);
        step();
        check("post_reset_qa0", q_a0, 32'h11);
        check("post_reset_qb0", q_b0, 32'h55555555);
        check("post_reset_nostale_qa1", q_a1, 32'h0);
        check("post_reset_nostale_qb1", q_b1, 32'h0);
        step();
        check("post_reset_qa1", q_a1, 32'h11BBCC44);
        check("post_reset_qb1", q_b1, 32'h00FF00FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
